boot_word_receiver: RTL
=======================

# boot_word_receiver

Serial-to-parallel bootloader front end that sits directly upstream of instruction memory. It samples an externally clocked two-wire serial stream (data clock plus data line) in the `clk` domain and assembles the bits MSB-first into 32-bit words. Each completed word is presented with a sequential 12-bit write address and a one-cycle `ready` strobe, which the memory-load path uses as its write enable while the CPU is held in reset.

## Interface
- `WORD_BITS`, 32, bits per assembled word.
- `ADDR_BITS`, 12, width of the word address counter.
- `TIMEOUT_CYCLES`, 50000, idle `clk` cycles mid-word after which the partial word is discarded.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `dataOnPin`  input  1  external serial clock, asynchronous to `clk`; a bit is valid on its rising edge.
- `dataPin`  input  1  external serial data, asynchronous; sampled on the `dataOnPin` rising edge.
- `ready`  output  1  one-cycle strobe: `out`/`addr` hold a new word.
- `out`  output  WORD_BITS  last completed word.
- `addr`  output  ADDR_BITS  address of the word in `out`.
- `busy`  output  1  high while a partial word is held (bit count ≠ 0).
- `frame_err`  output  1  one-cycle pulse when a partial word is dropped on timeout.

## Operation
- Synchronizer: `dataOnPin` and `dataPin` each pass through 2 flops. A third flop holds the previous synchronized `dataOnPin`. An edge is detected when the synchronized value is 1 and the previous value is 0.
- State machine:
  - IDLE: bit count = 0. On an edge, shift in the synchronized `dataPin`, set count = 1, clear the timeout counter, and go to SHIFT.
  - SHIFT: on each edge, `shreg <= {shreg[WORD_BITS-2:0], bit}` and increment count.
    - When the edge delivers bit number WORD_BITS, go to EMIT.
    - With no edge, the timeout counter increments. When it reaches TIMEOUT_CYCLES−1, clear count and shreg, pulse `frame_err`, and go to IDLE.
  - EMIT (one cycle): `out <= shreg`, `ready <= 1`. `addr` is unchanged and names this word. Go to IDLE.
    - An edge arriving in EMIT is not lost: it is shifted in as bit 1 of the next word and the next state is SHIFT.
- Address: on the cycle after `ready`, `addr <= addr + 1` modulo 2^ADDR_BITS (4095 wraps to 0). Address 0 is the first word after reset.
- `out` holds its value until the next EMIT. It is valid only while `ready` = 1.
- Reset mid-word drops the partial word. There is no `ready` and no `frame_err`; `addr` returns to 0.
- Reset values: `ready`=0, `out`=0, `addr`=0, `busy`=0, `frame_err`=0, count=0, state=IDLE, synchronizer flops=0.

## Timing
- Serial clock limits: `dataOnPin` high and low phases must each be ≥ 3 `clk` cycles. `dataPin` must be stable from 3 cycles before to 3 cycles after the rising edge. Faster input is out of spec.
- Edge latency: a rising `dataOnPin` at cycle t is detected at cycle t+2 (third synchronizer stage compare). The bit is in `shreg` after the t+2 clock edge.
- Word latency: `ready` is high during the cycle after the detect cycle of bit 32, i.e. 3 cycles after the raw 32nd rising edge. `addr` increments 1 cycle later.
- `ready` and `frame_err` are never high simultaneously and never high for 2 consecutive cycles.
- Throughput: back-to-back words with no gap are supported at the minimum serial period of 6 `clk` cycles.
- `busy` is registered: high from the cycle after bit 1 is captured through the EMIT cycle, and low in IDLE.

## Test plan
- Reset, then idle 100 cycles: all outputs stay 0, with `ready`, `frame_err` and `busy` never asserted.
- Send 0xDEADBEEF MSB-first at a 10-cycle serial period: a single `ready` pulse with `out`=0xDEADBEEF and `addr`=0, then `addr`=1 the next cycle.
- Send 3 words back-to-back at the 6-cycle minimum (0x00000001, 0x80000000, 0xA5A5A5A5): 3 `ready` pulses with addr 0, 1, 2 and exactly those values, no bits lost or duplicated.
- Send 17 bits, then idle for TIMEOUT_CYCLES (set to 100 in the bench): `frame_err` pulses once and `busy` drops. The next full word 0x12345678 appears with `addr`=0.
- Preload `addr` to 4095 by sending 4095 words with a small ADDR_BITS override, or force it. The next word gives `ready` with `addr`=4095, then `addr` wraps to 0.
- Assert `reset` after 20 bits of 0xFFFFFFFF: no `ready` and all outputs 0. After release, 0x0F0F0F0F is received intact at `addr`=0.

Source files
------------

// File: rtl/boot_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : boot_word_receiver
// Description : Two-wire serial bootloader front end. Synchronises an
//               externally clocked bit stream, assembles MSB-first words and
//               presents each with a sequential write address and a
//               one-cycle ready strobe for instruction-memory loading.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_word_receiver #(
    parameter int WORD_BITS      = 32,
    parameter int ADDR_BITS      = 12,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dataOnPin,
    input  logic                 dataPin,
    output logic                 ready,
    output logic [WORD_BITS-1:0] out,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    logic                 on_meta_q, on_sync_q, on_prev_q;
    logic                 dat_meta_q, dat_sync_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [WORD_BITS-1:0] out_q, out_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    logic                 w_edge;
    logic                 w_bit;
    logic [WORD_BITS-1:0] w_shift;
    logic [WORD_BITS-1:0] w_first;

    // Two-flop synchronisers for both pins plus a history flop for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_meta_q  <= 1'b0;
            on_sync_q  <= 1'b0;
            on_prev_q  <= 1'b0;
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
        end else begin
            on_meta_q  <= dataOnPin;
            on_sync_q  <= on_meta_q;
            on_prev_q  <= on_sync_q;
            dat_meta_q <= dataPin;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign w_edge  = on_sync_q & ~on_prev_q;
    assign w_bit   = dat_sync_q;
    assign w_shift = {shreg_q[WORD_BITS-2:0], w_bit};
    assign w_first = {{(WORD_BITS-1){1'b0}}, w_bit};

    // Next-state logic: word assembly, emit handoff and mid-word timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_edge) begin
                    shreg_d = w_first;
                    cnt_d   = CNT_W'(1);
                    to_d    = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_edge) begin
                    shreg_d = w_shift;
                    cnt_d   = cnt_q + CNT_W'(1);
                    to_d    = '0;
                    if (cnt_q == C_LAST_BIT) begin
                        // Word complete: out/ready are valid during the EMIT cycle
                        out_d   = w_shift;
                        ready_d = 1'b1;
                        state_d = S_EMIT;
                    end
                end else if (to_q == C_TO_LAST) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    to_d    = '0;
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_EMIT: begin
                // A bit arriving here starts the next word rather than being lost
                if (w_edge) begin
                    shreg_d = w_first;
                    cnt_d   = CNT_W'(1);
                    to_d    = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (cnt_d != '0);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= '0;
            shreg_q <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Address advances the cycle after ready so addr names the word being emitted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (ready_q) begin
            addr_q <= addr_q + ADDR_BITS'(1);
        end
    end

    assign ready     = ready_q;
    assign out       = out_q;
    assign addr      = addr_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;

endmodule
`default_nettype wire
